// File: rtl/alu_serial_seq.sv
// Purpose : bit-serial ALU sequencer; feeds an external 1-bit ALU LSB first and assembles a WIDTH-bit result.
// Latency : start accepted at cycle 0, busy for cycles 1..WIDTH, done pulses at cycle WIDTH+1.
// Backpress: none; start is ignored outside IDLE (no queuing), re-issue no earlier than the cycle after done.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start, op, a, b     operation request; op/a/b captured when start is accepted in IDLE
//   busy, done          busy while bits are processed, one-cycle completion pulse
//   result, carry, zero assembled result, final carry (ADD/SUB only), result==0 flag
//   alu_a/b/cin/op      drive to the external combinational 1-bit ALU
//   alu_y, alu_cout     same-cycle return from the 1-bit ALU
//
// Build option: define ALU_SERIAL_SEQ_SUB_EN to enable op 001 = A - B
// (carry=1 means no borrow). Without it op 001 behaves as an undefined opcode.

module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic             alu_y,
  input  logic             alu_cout
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       op_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic             op_valid;
  logic             is_arith;
  logic             bit_y;
  logic             last_bit;
  logic [WIDTH-1:0] result_nxt;

`ifdef ALU_SERIAL_SEQ_SUB_EN
  logic             sub_q;
`endif

  // Opcode decode on the captured op. Undefined opcodes have their ALU
  // output masked so the result is 0 whatever the external ALU returns.
  always_comb begin
    op_valid = 1'b0;
    is_arith = 1'b0;
    case (op_q)
      3'b000: begin op_valid = 1'b1; is_arith = 1'b1; end
`ifdef ALU_SERIAL_SEQ_SUB_EN
      3'b001: begin op_valid = 1'b1; is_arith = 1'b1; end
`endif
      3'b010, 3'b011, 3'b100, 3'b101: op_valid = 1'b1;
      default: begin op_valid = 1'b0; is_arith = 1'b0; end
    endcase
  end

  assign bit_y      = op_valid & alu_y;
  assign result_nxt = {bit_y, result[WIDTH-1:1]};
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  // Drive to the 1-bit ALU: live only in RUN, otherwise parked on op 111.
  always_comb begin
    alu_a   = 1'b0;
    alu_b   = 1'b0;
    alu_cin = 1'b0;
    alu_op  = 3'b111;
    if (state == S_RUN) begin
      alu_a   = a_sh[0];
      alu_cin = carry_q;
`ifdef ALU_SERIAL_SEQ_SUB_EN
      // Subtraction is A + ~B + 1 on the adder.
      alu_b   = b_sh[0] ^ sub_q;
      alu_op  = sub_q ? 3'b000 : op_q;
`else
      alu_b   = b_sh[0];
      alu_op  = op_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b1;
      a_sh    <= '0;
      b_sh    <= '0;
      op_q    <= 3'b000;
      carry_q <= 1'b0;
      cnt     <= '0;
`ifdef ALU_SERIAL_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            op_q    <= op;
            result  <= '0;
            zero    <= 1'b1;
            cnt     <= '0;
`ifdef ALU_SERIAL_SEQ_SUB_EN
            sub_q   <= (op == 3'b001);
            carry_q <= (op == 3'b001);
`else
            carry_q <= 1'b0;
`endif
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end

        S_RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          result  <= result_nxt;
          carry_q <= alu_cout;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            // Flags are registered on entry to DONE so they are valid
            // in the same cycle as the done pulse.
            busy  <= 1'b0;
            done  <= 1'b1;
            carry <= is_arith & alu_cout;
            zero  <= (result_nxt == '0);
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Purpose : self-checking bench for alu_serial_seq (WIDTH=8) with a behavioural 1-bit ALU.
// Latency : checks done at exactly cycle WIDTH+1 and busy over cycles 1..WIDTH.
// Backpress: exercises held start, back-to-back issue, input changes in RUN and mid-op reset.

module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         alu_a;
  logic         alu_b;
  logic         alu_cin;
  logic [2:0]   alu_op;
  logic         alu_y;
  logic         alu_cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_op   (alu_op),
    .alu_y    (alu_y),
    .alu_cout (alu_cout)
  );

  // External combinational 1-bit ALU.
  always_comb begin
    alu_y    = 1'b0;
    alu_cout = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_y    = alu_a ^ alu_b ^ alu_cin;
        alu_cout = (alu_a & alu_b) | (alu_a & alu_cin) | (alu_b & alu_cin);
      end
      3'b010: alu_y = alu_a & alu_b;
      3'b011: alu_y = alu_a | alu_b;
      3'b100: alu_y = alu_a ^ alu_b;
      3'b101: alu_y = ~alu_a;
      default: begin
        alu_y    = 1'b0;
        alu_cout = 1'b0;
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word-level reference: returns {carry, result}.
  function automatic logic [W:0] ref_alu(input logic [2:0] f_op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W:0] one;
    one = {{W{1'b0}}, 1'b1};
    case (f_op)
      3'b000: return {1'b0, x} + {1'b0, y};
`ifdef ALU_SERIAL_SEQ_SUB_EN
      3'b001: return {1'b0, x} + {1'b0, ~y} + one;
`endif
      3'b010: return {1'b0, x & y};
      3'b011: return {1'b0, x | y};
      3'b100: return {1'b0, x ^ y};
      3'b101: return {1'b0, ~x};
      default: return '0;
    endcase
  endfunction

  // Issue one op, check busy/done cycle by cycle and the final outputs.
  task automatic run_op(input logic [2:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                        input logic [W-1:0] exp_r, input logic exp_c, input string name);
    int bad;
    logic [W-1:0] got_r;
    logic got_c;
    logic got_z;
    bad = 0;
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk);          // cycle 0: accepted
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom);
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    @(negedge clk);          // cycle W+1
    if (busy !== 1'b0 || done !== 1'b1) bad++;
    got_r = result; got_c = carry; got_z = zero;
    @(negedge clk);
    if (done !== 1'b0 || result !== got_r) bad++;
    check({name, " timing"}, 32'(bad), 32'd0);
    check({name, " result"}, 32'(got_r), 32'(exp_r));
    check({name, " carry"},  32'(got_c), 32'(exp_c));
    check({name, " zero"},   32'(got_z), 32'(exp_r == '0));
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W:0] m;
    logic [2:0] r_op;
    logic [W-1:0] r_a, r_b;
    int done_cnt, d1_cyc, d2_cyc, bad;
    logic [W-1:0] d1_res, d2_res;

    tbl[0] = '{3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0};
    tbl[1] = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0};
    tbl[3] = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    tbl[4] = '{3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0};
    tbl[5] = '{3'b101, 8'h0F, 8'h33, 8'hF0, 1'b0};
`ifdef ALU_SERIAL_SEQ_SUB_EN
    tbl[6] = '{3'b001, 8'h10, 8'h01, 8'h0F, 1'b1};
`else
    tbl[6] = '{3'b001, 8'h10, 8'h01, 8'h00, 1'b0};
`endif
    tbl[7] = '{3'b110, 8'h5A, 8'h3C, 8'h00, 1'b0};
    tbl[8] = '{3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy",   32'(busy),   32'd0);
    check("reset done",   32'(done),   32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset carry",  32'(carry),  32'd0);
    check("reset zero",   32'(zero),   32'd1);
    check("reset alu_op", 32'(alu_op), 32'd7);
    check("reset alu_abc", 32'({alu_a, alu_b, alu_cin}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].c, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = W'($urandom);
      r_b  = W'($urandom);
      m    = ref_alu(r_op, r_a, r_b);
      run_op(r_op, r_a, r_b, m[W-1:0], m[W], $sformatf("rnd%0d op%0d", i, r_op));
    end

    // Start held high: one result per acceptance, operand change in RUN ignored,
    // second op accepted the cycle after done.
    done_cnt = 0; d1_cyc = -1; d2_cyc = -1; d1_res = '0; d2_res = '0; bad = 0;
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'h5A; b = 8'h3C;
    @(posedge clk);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 8 && alu_op !== 3'b000) bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin d1_cyc = c; d1_res = result; end
        if (done_cnt == 2) begin d2_cyc = c; d2_res = result; end
      end
      if (c == 3) begin a = 8'h11; b = 8'h22; end
      if (c == 11) start = 1'b0;
    end
    check("hold done count",  32'(done_cnt), 32'd2);
    check("hold done1 cycle", 32'(d1_cyc),   32'd9);
    check("hold result1",     32'(d1_res),   32'h96);
    check("hold done2 cycle", 32'(d2_cyc),   32'd19);
    check("hold result2",     32'(d2_res),   32'h33);
    check("hold alu_op run",  32'(bad),      32'd0);

    // Reset in the middle of an ADD.
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst busy",   32'(busy),   32'd0);
    check("midrst done",   32'(done),   32'd0);
    check("midrst result", 32'(result), 32'd0);
    check("midrst zero",   32'(zero),   32'd1);
    check("midrst carry",  32'(carry),  32'd0);
    rst_n = 1'b1;
    // Fresh start on the first cycle after reset release; an echo of the
    // aborted op would show up as an early done in the timing check.
    run_op(3'b000, 8'h80, 8'h80, 8'h00, 1'b1, "post reset add");
    run_op(3'b100, 8'h3C, 8'hC3, 8'hFF, 1'b0, "post reset xor");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
